// File: rtl/calc_input_ctrl.sv
// Board front-end for the four-function calculator: synchronises and debounces the
// switches and keys, sequences operand/operator entry and hands one command to the core.
//
// state  | meaning
// S_A    | waiting for enter to capture operand A
// S_B    | waiting for enter to capture operand B and opcode
// S_GO   | issuing the single-cycle go pulse
// S_WAIT | command in flight, waiting for done from the core
module calc_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sw,
  input  logic [3:0] key,
  input  logic       done,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic [1:0] op,
  output logic       go,
  output logic       busy,
  output logic [1:0] stage
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_GO   = 2'b10,
    S_WAIT = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       sw_m, sw_s;
  logic [1:0]       key_m, key_s, key_db, press;
  logic [CNT_W-1:0] cnt [2];
  logic             load_a, load_b;
  logic             unused_keys;

  assign unused_keys = &{1'b0, key[3:2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_m  <= '0;
      sw_s  <= '0;
      key_m <= 2'b11;
      key_s <= 2'b11;
    end else begin
      sw_m  <= sw;
      sw_s  <= sw_m;
      key_m <= key[1:0];
      key_s <= key_m;
    end
  end

  // press is registered off the debounced falling edge, so it lasts exactly one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
      key_db <= 2'b11;
      press  <= 2'b00;
    end else begin
      press <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (key_s[i] == key_db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
          key_db[i] <= ~key_db[i];
          cnt[i]    <= '0;
          press[i]  <= key_db[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    go      = 1'b0;
    busy    = 1'b0;
    case (state_q)
      S_A: begin
        if (press[0]) begin
          load_a  = 1'b1;
          state_d = S_B;
        end
      end
      S_B: begin
        if (press[0]) begin
          load_b  = 1'b1;
          state_d = S_GO;
        end
      end
      S_GO: begin
        go      = 1'b1;
        busy    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (done) state_d = S_A;
      end
      default: state_d = S_A;
    endcase
    // clear overrides enter, done and the pending go
    if (press[1]) begin
      state_d = S_A;
      load_a  = 1'b0;
      load_b  = 1'b0;
      go      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_A;
      op_a    <= '0;
      op_b    <= '0;
      op      <= '0;
    end else begin
      state_q <= state_d;
      if (load_a) op_a <= sw_s[7:0];
      if (load_b) begin
        op_b <= sw_s[7:0];
        op   <= sw_s[9:8];
      end
    end
  end

  assign stage = state_q;

endmodule

// File: tb/tb_calc_input_ctrl.sv
// Bench for calc_input_ctrl: directed test-plan steps followed by random key/switch/done
// traffic, all compared each cycle against a behavioural model of the entry protocol.
module tb_calc_input_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] sw;
  logic [3:0] key;
  logic       done;
  logic [7:0] op_a, op_b;
  logic [1:0] op, stage;
  logic       go, busy;

  int n_tests = 0;
  int n_fail  = 0;

  calc_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk(clk), .reset(reset), .sw(sw), .key(key), .done(done),
    .op_a(op_a), .op_b(op_b), .op(op), .go(go), .busy(busy), .stage(stage)
  );

  always #5 clk = ~clk;

  // Model: history of synchronised key samples; a level is accepted once D+1
  // consecutive samples disagree with it. The protocol is a plain step counter 0..3.
  logic [9:0] m_sw1, m_sw2;
  logic [1:0] m_k1, m_k2, m_db, m_press;
  int         m_hist [2][$];
  int         m_step;
  logic [7:0] m_a, m_b;
  logic [1:0] m_op;

  task automatic model_step(input logic [9:0] s, input logic [3:0] k, input logic d, input logic r);
    logic [1:0] np;
    bit         all_diff;
    if (r) begin
      m_sw1 = '0; m_sw2 = '0; m_k1 = 2'b11; m_k2 = 2'b11; m_db = 2'b11;
      m_press = 2'b00; m_step = 0; m_a = '0; m_b = '0; m_op = '0;
      m_hist[0].delete(); m_hist[1].delete();
      return;
    end
    if (m_press[1]) m_step = 0;
    else if (m_step == 0 && m_press[0]) begin m_a = m_sw2[7:0]; m_step = 1; end
    else if (m_step == 1 && m_press[0]) begin m_b = m_sw2[7:0]; m_op = m_sw2[9:8]; m_step = 2; end
    else if (m_step == 2) m_step = 3;
    else if (m_step == 3 && d) m_step = 0;
    np = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_hist[i].push_back(int'(m_k2[i]));
      if (m_hist[i].size() > D + 1) void'(m_hist[i].pop_front());
      all_diff = (m_hist[i].size() == D + 1);
      foreach (m_hist[i][j]) if (m_hist[i][j] == int'(m_db[i])) all_diff = 0;
      if (all_diff) begin
        np[i]   = m_db[i];
        m_db[i] = ~m_db[i];
        m_hist[i].delete();
      end
    end
    m_press = np;
    m_sw2 = m_sw1; m_sw1 = s;
    m_k2 = m_k1;   m_k1 = k[1:0];
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("stage", int'(stage), m_step);
    chk("busy",  int'(busy),  int'(m_step >= 2));
    chk("go",    int'(go),    int'(m_step == 2 && !m_press[1]));
    chk("op_a",  int'(op_a),  int'(m_a));
    chk("op_b",  int'(op_b),  int'(m_b));
    chk("op",    int'(op),    int'(m_op));
  endtask

  task automatic cyc(input logic [9:0] s, input logic [3:0] k, input logic d, input logic r);
    sw = s; key = k; done = d; reset = r;
    @(posedge clk);
    model_step(s, k, d, r);
    @(negedge clk);
    chk_model();
  endtask

  task automatic press_keys(input logic [9:0] s, input logic [3:0] k);
    repeat (10) cyc(s, k, 1'b0, 1'b0);
    repeat (10) cyc(s, 4'hF, 1'b0, 1'b0);
  endtask

  initial begin
    int lat, gos, trans;
    logic [1:0] prev;
    logic [9:0] rs;
    logic [3:0] rk;
    int r;

    sw = '0; key = 4'hF; done = 1'b0; reset = 1'b1;
    repeat (3) cyc(10'h000, 4'hF, 1'b0, 1'b1);
    repeat (20) cyc(10'h000, 4'hF, 1'b0, 1'b0);
    chk("rst_stage", int'(stage), 0);
    chk("rst_opa",   int'(op_a),  0);
    chk("rst_opb",   int'(op_b),  0);
    chk("rst_op",    int'(op),    0);
    chk("rst_go",    int'(go),    0);
    chk("rst_busy",  int'(busy),  0);

    // operand A: stage moves D+4 edges after the first low sample
    repeat (4) cyc(10'h02A, 4'hF, 1'b0, 1'b0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(10'h02A, 4'hE, 1'b0, 1'b0);
      if (lat == 0 && stage == 2'b01) lat = i;
    end
    chk("lat_a", lat, D + 4);
    chk("a_val", int'(op_a), 'h2A);
    repeat (10) cyc(10'h02A, 4'hF, 1'b0, 1'b0);

    // operand B + opcode, single go
    repeat (5) cyc(10'h305, 4'hF, 1'b0, 1'b0);
    gos = 0;
    repeat (20) begin cyc(10'h305, 4'hE, 1'b0, 1'b0); gos += int'(go); end
    repeat (10) begin cyc(10'h305, 4'hF, 1'b0, 1'b0); gos += int'(go); end
    chk("b_val",  int'(op_b),  'h05);
    chk("b_op",   int'(op),    3);
    chk("b_go",   gos,         1);
    chk("b_busy", int'(busy),  1);
    chk("b_stg",  int'(stage), 3);

    cyc(10'h305, 4'hF, 1'b1, 1'b0);
    chk("done_stg",  int'(stage), 0);
    chk("done_busy", int'(busy),  0);
    chk("done_a",    int'(op_a),  'h2A);
    chk("done_b",    int'(op_b),  'h05);

    // short glitches never press
    repeat (5) begin
      repeat (3) cyc(10'h011, 4'hE, 1'b0, 1'b0);
      repeat (3) cyc(10'h011, 4'hF, 1'b0, 1'b0);
    end
    repeat (6) cyc(10'h011, 4'hF, 1'b0, 1'b0);
    chk("glitch_stg", int'(stage), 0);

    // long hold is one press
    trans = 0; prev = stage;
    repeat (50) begin
      cyc(10'h011, 4'hE, 1'b0, 1'b0);
      if (stage != prev) trans++;
      prev = stage;
    end
    repeat (10) cyc(10'h011, 4'hF, 1'b0, 1'b0);
    chk("hold_trans", trans, 1);
    chk("hold_a",     int'(op_a), 'h11);

    // enter and clear together in S_B: clear wins
    gos = 0;
    repeat (10) begin cyc(10'h1FF, 4'hC, 1'b0, 1'b0); gos += int'(go); end
    repeat (10) begin cyc(10'h1FF, 4'hF, 1'b0, 1'b0); gos += int'(go); end
    chk("clr_stg", int'(stage), 0);
    chk("clr_go",  gos,         0);
    chk("clr_b",   int'(op_b),  'h05);

    // reset in S_WAIT, then a stale done
    press_keys(10'h033, 4'hE);
    press_keys(10'h144, 4'hE);
    chk("w_stg", int'(stage), 3);
    cyc(10'h144, 4'hF, 1'b0, 1'b1);
    chk("wr_stg", int'(stage), 0);
    chk("wr_a",   int'(op_a),  0);
    chk("wr_b",   int'(op_b),  0);
    chk("wr_op",  int'(op),    0);
    chk("wr_bsy", int'(busy),  0);
    cyc(10'h144, 4'hF, 1'b1, 1'b0);
    cyc(10'h144, 4'hF, 1'b0, 1'b0);
    chk("late_stg", int'(stage), 0);
    chk("late_bsy", int'(busy),  0);

    // random traffic
    for (int seg = 0; seg < 400; seg++) begin
      rs = 10'($urandom);
      r  = int'($urandom_range(0, 9));
      rk = (r < 4) ? 4'hF : (r < 8) ? 4'hE : (r == 8) ? 4'hD : 4'hC;
      rk[3:2] = 2'($urandom);
      repeat ($urandom_range(1, 12))
        cyc(rs, rk, $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_input_ctrl.md
Name: calc_input_ctrl

Overview:
Front-end for the four-function calculator that accepts the board stimulus the bench tester drives, i.e. sw[9:0] and key[3:0].
- Synchronises and debounces the active-low pushbuttons.
- Turns each button press into a single event.
- Sequences operand/operator entry with a small FSM.
- Presents one registered command (operands, opcode, go pulse) to the calculator core and waits for its done.
Sits between the board pins and the calculator datapath.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a key level must be stable before a press or release is accepted (board builds use 500000).
CNT_W, 20, width of each debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
sw  input  10  raw switches; sw[7:0] operand, sw[9:8] opcode (00 add, 01 sub, 10 mul, 11 div).
key  input  4  raw pushbuttons, active low; key[0] enter, key[1] clear, key[3:2] unused.
done  input  1  calculator core finished; a 1-cycle pulse.
op_a  output  8  registered operand A.
op_b  output  8  registered operand B.
op  output  2  registered opcode.
go  output  1  1-cycle start pulse to the core.
busy  output  1  high while waiting for done.
stage  output  2  FSM state encoding, for LEDR display.

Behaviour:
Reset:
- When reset is high at a clk edge: op_a=0, op_b=0, op=0, go=0, busy=0, stage=S_A.
- Synchroniser flops load 1 (released). Debounce counters load 0; debounced levels load released.
- Reset mid-entry or mid-WAIT aborts to S_A.
- A done arriving after reset is ignored.

Input conditioning:
- sw and key[1:0] each pass through a 2-flop synchroniser.
- Per key, a counter increments while the synchronised level differs from the debounced level, and clears to 0 when they match.
- When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- A debounced 1->0 transition produces press_x, high for exactly 1 cycle.
- Latency: key held low from edge k gives press_x high in cycle k+2+DEBOUNCE_CYCLES.
- Holding a key produces exactly one press.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no press.
- A new press needs a debounced release first.

FSM (stage encoding: S_A=00, S_B=01, S_GO=10, S_WAIT=11):
- S_A, on press_enter: op_a <= sync sw[7:0]; go to S_B.
- S_B, on press_enter: op_b <= sync sw[7:0]; op <= sync sw[9:8]; go to S_GO.
- S_GO: go=1 for this single cycle, busy=1; go to S_WAIT unconditionally.
- S_WAIT: busy=1. On done, busy falls and the next state is S_A. op_a, op_b and op hold their values until overwritten.
- Outputs change on the edge after the press cycle.

Event rules:
- press_clear in any state returns to S_A and leaves op_a/op_b/op unchanged.
- press_clear in S_GO suppresses go.
- press_enter and press_clear in the same cycle: clear wins.
- press_enter in S_GO or S_WAIT is ignored; it is not queued.
- done outside S_WAIT is ignored.
- done in the same cycle as press_clear: S_A.
- No timeout: S_WAIT holds until done, clear or reset.
- go is never asserted twice per command. busy is high exactly in S_GO and S_WAIT.

Test Plan:
- Reset then idle 20 cycles -> op_a=0, op_b=0, op=0, go=0, busy=0, stage=00.
- DEBOUNCE_CYCLES=4. sw=0x2A, key[0] low from edge 10 for 10 cycles, release; sw=0x305, key[0] low again -> op_a=0x2A at edge 17; op_b=0x05 and op=11 loaded; go high exactly 1 cycle; busy=1, stage=11.
- In S_WAIT, pulse done 1 cycle -> busy=0, stage=00 next edge; op_a/op_b/op retained.
- key[0] low for 3 cycles, repeated 5 times with 3-cycle gaps -> no press, stage stays 00. Holding key[0] low for 50 cycles -> exactly one transition.
- In S_B, key[0] and key[1] pressed on the same edge -> stage=00, no go, op_b unchanged.
- In S_WAIT, assert reset 1 cycle -> all outputs at reset values. A later done pulse leaves stage=00 and busy=0.
